// File: rtl/phase_clock_gen_pkg.sv
// Shared types for the phase clock generator: control states and the
// canonical five-phase index names.
package phase_clock_gen_pkg;

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2
  } state_e;

  localparam int unsigned PHASE_IF  = 0;
  localparam int unsigned PHASE_ID  = 1;
  localparam int unsigned PHASE_EX  = 2;
  localparam int unsigned PHASE_MEM = 3;
  localparam int unsigned PHASE_WB  = 4;

endpackage

// File: rtl/phase_clock_gen_prescaler.sv
// Prescaler for the phase generator: counts enabled clocks and ticks once every
// div_active+1 of them. A newly loaded divide value waits in div_pend until apply.
module phase_clock_gen_prescaler #(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 apply,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [DIV_WIDTH-1:0] div_active_q, div_active_d;
  logic [DIV_WIDTH-1:0] div_pend_q, div_pend_d;

  assign tick = en && (presc_q == div_active_q);

  always_comb begin
    presc_d      = presc_q;
    div_pend_d   = div_pend_q;
    div_active_d = div_active_q;
    if (en) begin
      presc_d = tick ? '0 : presc_q + DIV_WIDTH'(1);
    end
    if (div_load) begin
      div_pend_d = div_in;
    end
    if (apply) begin
      div_active_d = div_pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      div_active_q <= DIV_WIDTH'(DEFAULT_DIV);
      div_pend_q   <= DIV_WIDTH'(DEFAULT_DIV);
    end else begin
      presc_q      <= presc_d;
      div_active_q <= div_active_d;
      div_pend_q   <= div_pend_d;
    end
  end

endmodule

// File: rtl/phase_clock_gen.sv
// One-hot phase-enable generator for the multi-cycle core: run/halt/step control,
// stall hold, programmable phase rate and a completed-instruction counter.
module phase_clock_gen
  import phase_clock_gen_pkg::*;
#(
  parameter int unsigned NUM_PHASES  = 5,
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 0,
  parameter int unsigned START_RUN   = 1,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run_req,
  input  logic                          halt_req,
  input  logic                          step_req,
  input  logic                          stall,
  input  logic                          div_load,
  input  logic [DIV_WIDTH-1:0]          div_in,
  output logic [NUM_PHASES-1:0]         phase_en,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          instr_done,
  output logic                          halted,
  output logic [CNT_WIDTH-1:0]          instr_count
);

  localparam int unsigned PW = $clog2(NUM_PHASES);

  state_e                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic                  halt_pend_q, halt_pend_d;
  logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
  logic                  instr_done_q, instr_done_d;
  logic                  halted_q, halted_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic active, tick, last, boundary, apply;

  assign active   = (state_q != StHalt) && !stall;
  assign last     = (phase_q == PW'(NUM_PHASES - 1));
  assign boundary = tick && last;
  // While halted no instruction is in flight, so a new divide can take effect at once.
  assign apply    = boundary || (state_q == StHalt);

  phase_clock_gen_prescaler #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (active),
    .div_load(div_load),
    .div_in  (div_in),
    .apply   (apply),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    case (state_q)
      StHalt: begin
        if (run_req) begin
          state_d = StRun;
        end else if (step_req) begin
          state_d = StStep;
        end
      end
      StRun: begin
        // halt_req wins over a simultaneous run_req.
        if (halt_req) begin
          halt_pend_d = 1'b1;
        end else if (run_req) begin
          halt_pend_d = 1'b0;
        end
        if (boundary && (halt_pend_q || halt_req)) begin
          state_d     = StHalt;
          halt_pend_d = 1'b0;
        end
      end
      StStep: begin
        if (run_req) begin
          state_d = StRun;
        end else if (boundary) begin
          state_d = StHalt;
        end
      end
      default: state_d = StHalt;
    endcase

    phase_d      = phase_q;
    phase_en_d   = '0;
    instr_done_d = boundary;
    cnt_d        = boundary ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    if (tick) begin
      phase_en_d = NUM_PHASES'(1) << phase_q;
      phase_d    = last ? '0 : phase_q + PW'(1);
    end
    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= (START_RUN != 0) ? StRun : StHalt;
      halted_q     <= (START_RUN == 0);
      phase_q      <= '0;
      halt_pend_q  <= 1'b0;
      phase_en_q   <= '0;
      instr_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      phase_q      <= phase_d;
      halt_pend_q  <= halt_pend_d;
      phase_en_q   <= phase_en_d;
      instr_done_q <= instr_done_d;
      cnt_q        <= cnt_d;
    end
  end

  assign phase_en    = phase_en_q;
  assign phase_idx   = phase_q;
  assign instr_done  = instr_done_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_phase_clock_gen.sv
// Self-checking bench for phase_clock_gen: per-cycle expectations are queued as
// stimulus is driven and popped against the DUT one clock later.
module tb_phase_clock_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run_req, halt_req, step_req, stall, div_load;
  logic [7:0]  div_in;
  logic [4:0]  phase_en;
  logic [2:0]  phase_idx;
  logic        instr_done, halted;
  logic [31:0] instr_count;

  logic        rst_h, run_req_h;
  logic [4:0]  phase_en_h;
  logic [2:0]  phase_idx_h;
  logic        instr_done_h, halted_h;
  logic [31:0] instr_count_h;

  phase_clock_gen #(
    .NUM_PHASES(5), .DIV_WIDTH(8), .DEFAULT_DIV(0), .START_RUN(1), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .stall(stall), .div_load(div_load), .div_in(div_in), .phase_en(phase_en),
    .phase_idx(phase_idx), .instr_done(instr_done), .halted(halted),
    .instr_count(instr_count)
  );

  phase_clock_gen #(
    .NUM_PHASES(5), .DIV_WIDTH(8), .DEFAULT_DIV(0), .START_RUN(0), .CNT_WIDTH(32)
  ) dut_h (
    .clk(clk), .rst(rst_h), .run_req(run_req_h), .halt_req(1'b0), .step_req(1'b0),
    .stall(1'b0), .div_load(1'b0), .div_in(8'd0), .phase_en(phase_en_h),
    .phase_idx(phase_idx_h), .instr_done(instr_done_h), .halted(halted_h),
    .instr_count(instr_count_h)
  );

  typedef struct {
    logic [4:0] en;
    logic       done;
    logic       halted;
    int         cnt;  // -1: not checked
    int         idx;  // -1: not checked
  } exp_t;

  typedef struct {
    logic       halt_req;
    logic       run_req;
    logic [4:0] en;
    logic       done;
    int         cnt;
    int         idx;
  } vec_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc_n    = 0;
  string tag      = "init";

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic push(input logic [4:0] en, input logic done, input logic hlt,
                      input int cnt = -1, input int idx = -1);
    exp_t e;
    e.en = en; e.done = done; e.halted = hlt; e.cnt = cnt; e.idx = idx;
    exp_q.push_back(e);
  endtask

  // One clock: inputs driven before the call are sampled at this edge, pulses drop after it.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; div_load = 1'b0; run_req_h = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s.c%0d.phase_en", tag, cyc_n), phase_en, e.en);
      check($sformatf("%s.c%0d.instr_done", tag, cyc_n), instr_done, e.done);
      check($sformatf("%s.c%0d.halted", tag, cyc_n), halted, e.halted);
      if (e.cnt >= 0) check($sformatf("%s.c%0d.instr_count", tag, cyc_n), instr_count, e.cnt);
      if (e.idx >= 0) check($sformatf("%s.c%0d.phase_idx", tag, cyc_n), phase_idx, e.idx);
    end
  endtask

  task automatic step_exp(input logic [4:0] en, input logic done = 1'b0,
                          input logic hlt = 1'b0, input int cnt = -1, input int idx = -1);
    push(en, done, hlt, cnt, idx);
    cycle();
  endtask

  task automatic do_reset(input string name);
    tag = name;
    cyc_n = 0;
    exp_q.delete();
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; stall = 1'b0;
    div_load = 1'b0; div_in = 8'd0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check({name, ".rst.phase_en"}, phase_en, 0);
    check({name, ".rst.instr_done"}, instr_done, 0);
    check({name, ".rst.halted"}, halted, 0);
    check({name, ".rst.instr_count"}, instr_count, 0);
    check({name, ".rst.phase_idx"}, phase_idx, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t t1[15];
    rst = 1'b1; rst_h = 1'b1; run_req_h = 1'b0;
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; stall = 1'b0;
    div_load = 1'b0; div_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_h = 1'b0;

    // Free-running at div=0: one phase per clock, one instruction per five.
    for (int k = 1; k <= 15; k++) begin
      t1[k-1].halt_req = 1'b0;
      t1[k-1].run_req  = 1'b0;
      t1[k-1].en       = 5'd1 << ((k - 1) % 5);
      t1[k-1].done     = (k % 5 == 0);
      t1[k-1].cnt      = k / 5;
      t1[k-1].idx      = k % 5;
    end
    do_reset("t1");
    for (int i = 0; i < 15; i++) begin
      halt_req = t1[i].halt_req;
      run_req  = t1[i].run_req;
      step_exp(t1[i].en, t1[i].done, 1'b0, t1[i].cnt, t1[i].idx);
    end
    check("t1.count_after_15", instr_count, 3);

    // Divide change mid-instruction only takes effect at the boundary.
    do_reset("t2");
    step_exp(5'd1);
    step_exp(5'd2);
    step_exp(5'd4, 1'b0, 1'b0, -1, 3);
    div_load = 1'b1; div_in = 8'd3;
    step_exp(5'd8);
    step_exp(5'd16, 1'b1, 1'b0, 1, 0);
    repeat (3) step_exp(5'd0);
    step_exp(5'd1);
    repeat (3) step_exp(5'd0);
    step_exp(5'd2, 1'b0, 1'b0, 1, 2);

    // Halt completes the instruction, stays halted, run resumes, halt beats run.
    do_reset("t3");
    step_exp(5'd1);
    step_exp(5'd2);
    halt_req = 1'b1;
    step_exp(5'd4);
    step_exp(5'd8);
    step_exp(5'd16, 1'b1, 1'b1, 1, 0);
    repeat (20) step_exp(5'd0, 1'b0, 1'b1, 1, 0);
    run_req = 1'b1;
    step_exp(5'd0, 1'b0, 1'b0);
    step_exp(5'd1);
    halt_req = 1'b1; run_req = 1'b1;
    step_exp(5'd2);
    step_exp(5'd4);
    step_exp(5'd8);
    step_exp(5'd16, 1'b1, 1'b1, 2);
    step_exp(5'd0, 1'b0, 1'b1, 2);

    // Single step from HALT; a second step_req while stepping is ignored.
    tag = "t4";
    step_req = 1'b1;
    step_exp(5'd0, 1'b0, 1'b0, 2);
    step_req = 1'b1;
    step_exp(5'd1);
    step_exp(5'd2);
    step_exp(5'd4);
    step_exp(5'd8);
    step_exp(5'd16, 1'b1, 1'b1, 3, 0);
    repeat (5) step_exp(5'd0, 1'b0, 1'b1, 3, 0);

    // Stall at phase 3 with div=1.
    do_reset("t5");
    div_load = 1'b1; div_in = 8'd1;
    step_exp(5'd1);
    step_exp(5'd2);
    step_exp(5'd4);
    step_exp(5'd8);
    step_exp(5'd16, 1'b1, 1'b0, 1);
    step_exp(5'd0);
    step_exp(5'd1);
    step_exp(5'd0);
    step_exp(5'd2);
    step_exp(5'd0);
    step_exp(5'd4, 1'b0, 1'b0, -1, 3);
    stall = 1'b1;
    repeat (7) step_exp(5'd0, 1'b0, 1'b0, 1, 3);
    stall = 1'b0;
    step_exp(5'd0, 1'b0, 1'b0, -1, 3);
    step_exp(5'd8, 1'b0, 1'b0, -1, 4);
    step_exp(5'd0);
    step_exp(5'd16, 1'b1, 1'b0, 2, 0);

    // Reset mid-instruction drops it.
    do_reset("t6");
    step_exp(5'd1);
    step_exp(5'd2);
    step_exp(5'd4);
    step_exp(5'd8);
    step_exp(5'd16, 1'b1, 1'b0, 1);
    step_exp(5'd1);
    step_exp(5'd2);
    step_exp(5'd4, 1'b0, 1'b0, 1, 3);
    rst = 1'b1;
    step_exp(5'd0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    step_exp(5'd1, 1'b0, 1'b0, 0, 1);

    // START_RUN=0 instance: halted since reset, no pulses until run_req.
    tag = "t6h";
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("t6h.idle%0d.halted", i), halted_h, 1);
      check($sformatf("t6h.idle%0d.phase_en", i), phase_en_h, 0);
    end
    run_req_h = 1'b1;
    cycle();
    check("t6h.run.halted", halted_h, 0);
    check("t6h.run.phase_en", phase_en_h, 0);
    cycle();
    check("t6h.first.phase_en", phase_en_h, 1);
    check("t6h.first.instr_count", instr_count_h, 0);

    check("scoreboard.drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
